// File: rtl/i2s_mic_capture.sv
// I2S master receiver for the MEMS microphone: generates bit clock and word
// select, captures the left slot and averages REDUCE_FACTOR samples to PCM.
module i2s_mic_capture #(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int I2S_CLK_FREQ  = 1_500_000,
    parameter int I2S_DATA_SIZE = 24,
    parameter int DATA_OUT_SIZE = 16,
    parameter int REDUCE_FACTOR = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     i2s_clk,
    output logic                     i2s_ws,
    input  logic                     i2s_sd,
    output logic [DATA_OUT_SIZE-1:0] pcm_out,
    output logic                     pcm_ready
);
    localparam int HALF_DIV = CLK_FREQ / (2 * I2S_CLK_FREQ);
    localparam int DIV_W    = $clog2(HALF_DIV);
    localparam int RED_SH   = $clog2(REDUCE_FACTOR);
    localparam int ACC_W    = I2S_DATA_SIZE + RED_SH;
    localparam int CNT_W    = (RED_SH > 0) ? RED_SH : 1;
    // Averaging shift and MSB-aligned output slice folded into one shift.
    localparam int OUT_SH   = RED_SH + I2S_DATA_SIZE - DATA_OUT_SIZE;
    localparam int STAGES   = 1;

    logic [DIV_W-1:0]         div_cnt;
    logic                     div_tc;
    logic                     rise;
    logic                     fall;
    logic [5:0]               bit_cnt;
    logic                     sd_meta;
    logic                     sd_sync;
    logic [I2S_DATA_SIZE-1:0] shift_reg;
    logic                     cap;
    logic                     cap_last;
    logic [STAGES:0]          vld_pipe;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  smp_ext;
    logic signed [ACC_W-1:0]  sum;
    logic [CNT_W-1:0]         smp_cnt;
    logic                     last_smp;
    logic [DATA_OUT_SIZE-1:0] avg_q;

    assign div_tc = (div_cnt == DIV_W'(HALF_DIV - 1));
    assign rise   = div_tc & ~i2s_clk;
    assign fall   = div_tc & i2s_clk;
    assign i2s_ws = bit_cnt[5];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
            i2s_clk <= 1'b0;
            bit_cnt <= '0;
        end else begin
            if (div_tc) begin
                div_cnt <= '0;
                i2s_clk <= ~i2s_clk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (fall)
                bit_cnt <= bit_cnt + 6'd1;
        end
    end

    // Slot bit 0 is the I2S one-bit delay; right slot never matches this range.
    assign cap      = rise && (bit_cnt != 6'd0) && (bit_cnt <= 6'(I2S_DATA_SIZE));
    assign cap_last = rise && (bit_cnt == 6'(I2S_DATA_SIZE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sd_meta   <= 1'b0;
            sd_sync   <= 1'b0;
            shift_reg <= '0;
        end else begin
            sd_meta <= i2s_sd;
            sd_sync <= sd_meta;
            if (cap)
                shift_reg <= {shift_reg[I2S_DATA_SIZE-2:0], sd_sync};
        end
    end

    assign smp_ext  = ACC_W'($signed(shift_reg));
    assign sum      = acc + smp_ext;
    assign last_smp = (smp_cnt == CNT_W'(REDUCE_FACTOR - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            acc       <= '0;
            smp_cnt   <= '0;
            avg_q     <= '0;
            pcm_out   <= '0;
            pcm_ready <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[0] & last_smp, cap_last};
            if (vld_pipe[0]) begin
                if (last_smp) begin
                    avg_q   <= DATA_OUT_SIZE'(sum >>> OUT_SH);
                    acc     <= '0;
                    smp_cnt <= '0;
                end else begin
                    acc     <= sum;
                    smp_cnt <= smp_cnt + CNT_W'(1);
                end
            end
            pcm_ready <= vld_pipe[STAGES];
            if (vld_pipe[STAGES])
                pcm_out <= avg_q;
        end
    end
endmodule

// File: tb/tb_i2s_mic_capture.sv
// Bench for i2s_mic_capture: microphone models drive each DUT, a scoreboard
// queue per DUT holds expected PCM words popped by strobe monitors.
module tb_i2s_mic_capture;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_sck, a_ws, a_rdy;
    logic        a_sd = 1'b0;
    logic [15:0] a_pcm;
    logic        b_sck, b_ws, b_rdy;
    logic        b_sd = 1'b0;
    logic [15:0] b_pcm;

    always #5 clk = ~clk;

    i2s_mic_capture dut_a (
        .clk(clk), .rst_n(rst_n), .i2s_clk(a_sck), .i2s_ws(a_ws),
        .i2s_sd(a_sd), .pcm_out(a_pcm), .pcm_ready(a_rdy)
    );

    i2s_mic_capture #(.I2S_CLK_FREQ(3_125_000), .REDUCE_FACTOR(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .i2s_clk(b_sck), .i2s_ws(b_ws),
        .i2s_sd(b_sd), .pcm_out(b_pcm), .pcm_ready(b_rdy)
    );

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int rel_cyc = 0;
    int tc = 0;

    // Directed vectors: left sample of even/odd frame, filler bit, expected PCM.
    logic [23:0] va_s0  [4] = '{24'h123456, 24'h000300, 24'hFFFF00, 24'h000000};
    logic [23:0] va_s1  [4] = '{24'h123456, 24'h000500, 24'hFFFE00, 24'h000000};
    logic        va_fill[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] va_exp [4] = '{16'h1234, 16'h0004, 16'hFFFE, 16'h0000};

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Microphone A: the bench tracks slot position from the bit-clock falls.
    int a_pos = 0, a_frm = 0;
    always @(negedge a_sck or negedge rst_n) begin
        logic [23:0] s;
        if (!rst_n) begin
            a_pos = 0;
            a_frm = 0;
            q_a.delete();
        end else begin
            a_pos = (a_pos + 1) % 64;
            if (a_pos == 0) a_frm++;
            if (a_pos == 24 && a_frm[0]) q_a.push_back(va_exp[tc]);
        end
        s = a_frm[0] ? va_s1[tc] : va_s0[tc];
        a_sd = (a_pos >= 1 && a_pos <= 24) ? s[24 - a_pos] : va_fill[tc];
    end

    // Microphone B: alternating full-scale negative / positive samples.
    int b_pos = 0, b_frm = 0;
    always @(negedge b_sck or negedge rst_n) begin
        logic [23:0] s;
        if (!rst_n) begin
            b_pos = 0;
            b_frm = 0;
            q_b.delete();
        end else begin
            b_pos = (b_pos + 1) % 64;
            if (b_pos == 0) b_frm++;
            if (b_pos == 24) q_b.push_back(b_frm[0] ? 16'h7FFF : 16'h8000);
        end
        s = b_frm[0] ? 24'h7FFFFF : 24'h800000;
        b_sd = (b_pos >= 1 && b_pos <= 24) ? s[24 - b_pos] : 1'b0;
    end

    int   a_pops = 0, a_last = -1, b_pops = 0, b_last = -1;
    logic a_rdy_d = 1'b0, b_rdy_d = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            a_last = -1; a_rdy_d = 1'b0;
            b_last = -1; b_rdy_d = 1'b0;
        end else begin
            if (a_rdy_d) chk("a_strobe_width", a_rdy, 0);
            if (a_rdy) begin
                chk("a_queue_level", q_a.size(), 1);
                if (q_a.size() > 0) chk("a_pcm_out", a_pcm, q_a.pop_front());
                if (a_last < 0) chk("a_first_strobe", cyc - rel_cyc, 5843);
                else            chk("a_strobe_spacing", cyc - a_last, 8448);
                a_last = cyc;
                a_pops++;
            end
            a_rdy_d = a_rdy;
            if (b_rdy_d) chk("b_strobe_width", b_rdy, 0);
            if (b_rdy) begin
                chk("b_queue_level", q_b.size(), 1);
                if (q_b.size() > 0) chk("b_pcm_out", b_pcm, q_b.pop_front());
                if (b_last < 0) chk("b_first_strobe", cyc - rel_cyc, 786);
                else            chk("b_strobe_spacing", cyc - b_last, 2048);
                b_last = cyc;
                b_pops++;
            end
            b_rdy_d = b_rdy;
        end
    end

    // Word select may only move on a bit-clock fall, after 32 bit clocks.
    logic a_sck_p = 1'b0, a_ws_p = 1'b0;
    int   a_rises = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            a_sck_p = 1'b0; a_ws_p = 1'b0; a_rises = 0;
        end else begin
            if (a_sck && !a_sck_p) a_rises++;
            if (a_ws != a_ws_p) begin
                chk("ws_on_sck_fall", {30'd0, a_sck_p, a_sck}, 2);
                chk("ws_slot_len", a_rises, 32);
                a_rises = 0;
            end
            a_sck_p = a_sck;
            a_ws_p  = a_ws;
        end
    end

    task automatic do_reset(input int n);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk("rst_i2s_clk", {a_sck, b_sck}, 0);
        chk("rst_i2s_ws", {a_ws, b_ws}, 0);
        chk("rst_pcm_out", {a_pcm, b_pcm}, 0);
        chk("rst_pcm_ready", {a_rdy, b_rdy}, 0);
        rel_cyc = cyc;
        #1 rst_n = 1'b1;
    endtask

    task automatic check_sck_timing();
        int n = 0;
        int t0;
        while (!a_sck && n < 200) begin @(negedge clk); n++; end
        chk("sck_first_rise", cyc - rel_cyc, 33);
        t0 = cyc;
        while (a_sck && n < 400) begin @(negedge clk); n++; end
        while (!a_sck && n < 400) begin @(negedge clk); n++; end
        chk("sck_period", cyc - t0, 66);
    endtask

    task automatic wait_pops(input int target);
        int n = 0;
        while (a_pops < target && n < 20000) begin @(negedge clk); n++; end
        chk("a_strobe_arrived", a_pops >= target, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1);
    end

    initial begin
        int n;
        tc = 0;
        do_reset(5);
        check_sck_timing();
        wait_pops(2);
        tc = 1;
        wait_pops(3);
        tc = 2;
        wait_pops(4);
        tc = 3;
        wait_pops(5);
        tc = 0;
        n = 0;
        while (!(a_frm[0] == 1'b0 && a_pos == 10) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_left_bit10", a_pos, 10);
        do_reset(1);
        check_sck_timing();
        wait_pops(6);
        chk("a_queue_drained", q_a.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/i2s_mic_capture.md
# i2s_mic_capture

I2S master receiver and decimator for the MEMS microphone front end. Generates the I2S bit clock and word select, deserialises the left-channel 24-bit sample each frame, and averages REDUCE_FACTOR consecutive samples. Emits a DATA_OUT_SIZE-bit PCM word with a one-cycle strobe. Sits directly upstream of the byte-packing FIFO writer, which consumes `pcm_out`/`pcm_ready`.

## Interface
- CLK_FREQ, 100_000_000: system clock frequency, Hz.
- I2S_CLK_FREQ, 1_500_000: target bit-clock frequency, Hz.
  - HALF_DIV = CLK_FREQ/(2*I2S_CLK_FREQ), integer-truncated; must be ≥ 4.
- I2S_DATA_SIZE, 24: valid bits per microphone slot, MSB first; ≤ 31.
- DATA_OUT_SIZE, 16: PCM output width; ≤ I2S_DATA_SIZE.
- REDUCE_FACTOR, 2: samples averaged per output; power of two, ≥ 1.
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low; clock clk.
- i2s_clk  out  1  bit clock, registered, 50% duty.
- i2s_ws  out  1  word select; 0 = left slot, 1 = right slot.
- i2s_sd  in  1  serial data from microphone; asynchronous.
- pcm_out  out  DATA_OUT_SIZE  signed averaged sample; held between strobes.
- pcm_ready  out  1  one-cycle strobe when `pcm_out` updates.

## Operation
- Divider: counter 0..HALF_DIV-1. At terminal count it wraps to 0 and toggles `i2s_clk`.
  - Toggle 0→1 is a rise event; toggle 1→0 is a fall event.
- Frame: 6-bit `bit_cnt`, incremented (mod 64) on each fall event. `i2s_ws` = `bit_cnt[5]`, so it changes only on falling edges; 32 bit clocks per slot.
- Input: `i2s_sd` passes through a 2-flop synchroniser. The synchronised value is sampled on each rise event.
- Capture: on a rise event with `bit_cnt` in 1..I2S_DATA_SIZE, shift the sample into a shift register (MSB first).
  - Slot 0 is the I2S one-bit delay and is ignored.
  - Left slot bits I2S_DATA_SIZE+1..31 are ignored.
  - The whole right slot (ws=1) is ignored.
- Sample complete on the rise event at `bit_cnt` == I2S_DATA_SIZE. Treat the sample as signed two's complement.
- Decimation:
  - Accumulator is signed, I2S_DATA_SIZE+log2(REDUCE_FACTOR) bits wide; sample counter runs 0..REDUCE_FACTOR-1.
  - On a non-final sample: acc += sample, counter++.
  - On the final sample: avg = (acc + sample) >>> log2(REDUCE_FACTOR) (arithmetic shift, truncating toward −∞).
  - pcm_out = avg[I2S_DATA_SIZE-1 -: DATA_OUT_SIZE]. Then acc ← 0, counter ← 0, and `pcm_ready` pulses.
  - REDUCE_FACTOR = 1: every sample is output directly, with no accumulation.
- No overflow is possible: the accumulator width covers the full sum.
- No backpressure: the consumer must accept every strobe.
- Reset:
  - Divider, `bit_cnt`, shift register, accumulator, sample counter and synchroniser clear to 0.
  - `i2s_clk`=0, `i2s_ws`=0, `pcm_out`=0, `pcm_ready`=0.
  - A partial frame or partial average in progress is discarded; no strobe is issued for it.

## Timing
- `i2s_clk` first rises HALF_DIV cycles after reset release. Period = 2·HALF_DIV clk cycles (66 at defaults, ≈1.515 MHz).
- Frame = 64 bit clocks; output rate = 1/(64·REDUCE_FACTOR) of the bit clock (≈11.84 kHz at defaults).
- `i2s_sd` must be stable for ≥ 3 clk before the rise event; the synchroniser costs 2 cycles.
- The LSB is captured at clk edge E. The accumulator updates at E+1. `pcm_out` and `pcm_ready` are registered at E+2; the strobe is high for exactly one cycle.
- Strobes are spaced exactly 64·REDUCE_FACTOR·2·HALF_DIV clk cycles apart (8448 at defaults).
- First strobe: the end of the REDUCE_FACTOR-th complete left slot after reset.

## Test plan
- Reset/clock: hold rst_n low for 5 cycles, then release.
  - While reset is low: all outputs are 0.
  - `i2s_clk` rises at cycle 33 and has a 66-cycle period.
  - `i2s_ws` is low for 32 bit clocks, then high for 32; every transition coincides with an `i2s_clk` fall.
- Constant data: the bench drives 24'h123456 MSB-first in left slots 1..24 of every frame.
  - Response: `pcm_out`=16'h1234.
  - `pcm_ready` pulses once per 2 frames (every 8448 cycles) and is one cycle wide.
- Averaging: alternate left samples 24'h000300 and 24'h000500 → `pcm_out`=16'h0004.
  - Negative case: alternate 24'hFFFF00 and 24'hFFFE00 → `pcm_out`=16'hFFFE.
- Channel isolation: right slot driven all 1s, left slot all 0s → `pcm_out`=16'h0000 on every strobe.
  - Bits in left slot positions 0 and 25..31 driven to 1 → no effect.
- Reset mid-operation: drop rst_n for 1 cycle at left bit 10 of the first frame of a pair.
  - No `pcm_ready` for the aborted pair.
  - `i2s_clk`/`i2s_ws` restart from the reset state.
  - The next strobe is 2 full frames later, with the correct value.
- REDUCE_FACTOR=1, I2S_CLK_FREQ=3_125_000 (HALF_DIV=16): left samples 24'h800000, then 24'h7FFFFF.
  - Response: `pcm_out`=16'h8000, then 16'h7FFF.
  - Strobe spacing: 2048 cycles.
